// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states, flag positions.
// Flag register presence is controlled by the ALU_FLAGS_EN macro.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_SHL
    } state_t;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// Ripple-carry adder/subtractor; sub=1 computes in1 + ~in2 + 1.
// Shared by ADD/SUB and the multiply accumulate step.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   c;

    always_comb begin
        b    = sub ? ~in2 : in2;
        c    = '0;
        c[0] = sub;
        s    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = in1[i] ^ b[i] ^ c[i];
            c[i+1] = (in1[i] & b[i]) | (c[i] & (in1[i] ^ b[i]));
        end
    end

    assign cout = c[WIDTH];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf  = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: A/G registers, single-cycle logic/arith, multi-cycle MUL/SHL.
// Define ALU_FLAGS_EN to build the {N,Z,C,V} flag register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] buswire,
    input  logic             ain,
    input  logic             gin,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic [3:0]       flags
);

    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   g;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   sh;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   as_s;
    logic               as_c;
    logic               as_v;
    logic [2*WIDTH-1:0] madd;
    logic [2*WIDTH-1:0] acc_sum;
    logic               unused_mc;
    logic               unused_mv;
    logic [CNT_W-1:0]   n_sh;

    logic               upd;
    logic [WIDTH-1:0]   res;
    logic               c_n;
    logic               v_n;
    logic [3:0]         fl_n;

    alu_addsub #(.WIDTH(WIDTH)) u_as (
        .in1  (buswire),
        .in2  (a),
        .sub  (op == OP_SUB),
        .s    (as_s),
        .cout (as_c),
        .ovf  (as_v)
    );

    assign madd = mplier[0] ? mcand : '0;

    alu_addsub #(.WIDTH(2*WIDTH)) u_acc (
        .in1  (acc),
        .in2  (madd),
        .sub  (1'b0),
        .s    (acc_sum),
        .cout (unused_mc),
        .ovf  (unused_mv)
    );

    // Shift amounts past WIDTH behave like WIDTH: everything shifts out.
    assign n_sh = (buswire[CNT_W-1:0] > W_CNT) ? W_CNT : buswire[CNT_W-1:0];

    always_comb begin
        upd = 1'b0;
        res = g;
        c_n = 1'b0;
        v_n = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (gin) begin
                    unique case (op)
                        OP_ADD, OP_SUB: begin
                            upd = 1'b1;
                            res = as_s;
                            c_n = as_c;
                            v_n = as_v;
                        end
                        OP_AND: begin
                            upd = 1'b1;
                            res = buswire & a;
                        end
                        OP_OR: begin
                            upd = 1'b1;
                            res = buswire | a;
                        end
                        OP_XOR: begin
                            upd = 1'b1;
                            res = buswire ^ a;
                        end
                        OP_PASS: begin
                            upd = 1'b1;
                            res = buswire;
                        end
                        OP_MUL: begin
                            upd = 1'b0;
                        end
                        OP_SHL: begin
                            if (n_sh == '0) begin
                                upd = 1'b1;
                                res = a;
                            end
                        end
                        default: upd = 1'b0;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt == ONE) begin
                    upd = 1'b1;
                    res = acc_sum[WIDTH-1:0];
                    c_n = |acc_sum[2*WIDTH-1:WIDTH];
                    v_n = c_n;
                end
            end
            ST_SHL: begin
                if (cnt == ONE) begin
                    upd = 1'b1;
                    res = {sh[WIDTH-2:0], 1'b0};
                    c_n = sh[WIDTH-1];
                end
            end
            default: upd = 1'b0;
        endcase
    end

    always_comb begin
        fl_n        = '0;
        fl_n[FLG_N] = res[WIDTH-1];
        fl_n[FLG_Z] = (res == '0);
        fl_n[FLG_C] = c_n;
        fl_n[FLG_V] = v_n;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            a      <= '0;
            g      <= '0;
            mplier <= '0;
            sh     <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= upd;
            if (upd) begin
                g <= res;
            end
            unique case (state)
                ST_IDLE: begin
                    if (ain) begin
                        a <= buswire;
                    end
                    if (gin && op == OP_MUL) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= buswire;
                        acc    <= '0;
                        cnt    <= W_CNT;
                        busy_q <= 1'b1;
                        state  <= ST_MUL;
                    end else if (gin && op == OP_SHL && n_sh != '0) begin
                        sh     <= a;
                        cnt    <= n_sh;
                        busy_q <= 1'b1;
                        state  <= ST_SHL;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - ONE;
                    if (cnt == ONE) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_SHL: begin
                    sh  <= sh << 1;
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flg <= '0;
        end else if (upd) begin
            flg <= fl_n;
        end
    end

    assign flags = flg;
`else
    logic unused_fl;

    assign unused_fl = ^fl_n;
    assign flags     = 4'b0000;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign aluout = g;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, corner sequences, random ops.
// Expected flags are zero unless ALU_FLAGS_EN is defined.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

`ifdef ALU_FLAGS_EN
    localparam logic [3:0] FMASK = 4'hF;
`else
    localparam logic [3:0] FMASK = 4'h0;
`endif

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] buswire = '0;
    logic         ain = 1'b0;
    logic         gin = 1'b0;
    logic [2:0]   op = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] aluout;
    logic [3:0]   flags;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(W)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .buswire (buswire),
        .ain     (ain),
        .gin     (gin),
        .op      (op),
        .busy    (busy),
        .done    (done),
        .aluout  (aluout),
        .flags   (flags)
    );

    typedef struct {
        logic [15:0] a;
        logic [2:0]  o;
        logic [15:0] b;
        logic [15:0] g;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    task automatic model(input logic [15:0] a, input logic [2:0] o,
                         input logic [15:0] b, output logic [15:0] g,
                         output logic [3:0] f, output int lat);
        logic [31:0] p;
        int          n;
        logic        c;
        logic        v;
        c   = 1'b0;
        v   = 1'b0;
        lat = 0;
        g   = '0;
        case (o)
            3'd0: begin
                p = 32'(b) + 32'(a);
                g = p[15:0];
                c = p[16];
                v = (a[15] == b[15]) && (g[15] != b[15]);
            end
            3'd1: begin
                g = b - a;
                c = (b >= a);
                v = (a[15] != b[15]) && (g[15] != b[15]);
            end
            3'd2: g = a & b;
            3'd3: g = a | b;
            3'd4: g = a ^ b;
            3'd5: g = b;
            3'd6: begin
                p   = 32'(a) * 32'(b);
                g   = p[15:0];
                c   = (p[31:16] != 0);
                v   = c;
                lat = 16;
            end
            default: begin
                n = int'(b[4:0]);
                if (n > 16) n = 16;
                p   = 32'(a) << n;
                g   = p[15:0];
                c   = (n > 0) ? p[16] : 1'b0;
                lat = n;
            end
        endcase
        f = {g[15], g == 16'h0, c, v};
    endtask

    task automatic exec(input logic [15:0] av, input logic [2:0] o,
                        input logic [15:0] bv, output logic [15:0] g,
                        output logic [3:0] f, output int lat,
                        output logic d1, output logic d2);
        @(negedge clock);
        ain     = 1'b1;
        buswire = av;
        @(negedge clock);
        ain     = 1'b0;
        gin     = 1'b1;
        op      = o;
        buswire = bv;
        @(negedge clock);
        gin     = 1'b0;
        buswire = 16'($urandom);
        lat = 0;
        while (busy && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        g  = aluout;
        f  = flags;
        d1 = done;
        @(negedge clock);
        d2 = done;
    endtask

    task automatic check_op(input string name, input logic [15:0] av,
                            input logic [2:0] o, input logic [15:0] bv,
                            input logic [15:0] eg, input logic [3:0] ef,
                            input int elat);
        logic [15:0] g;
        logic [3:0]  f;
        int          lat;
        logic        d1;
        logic        d2;
        exec(av, o, bv, g, f, lat, d1, d2);
        chk({name, ".g"}, 32'(g), 32'(eg));
        chk({name, ".f"}, 32'(f), 32'(ef & FMASK));
        chk({name, ".lat"}, 32'(lat), 32'(elat));
        chk({name, ".done"}, {30'b0, d1, d2}, 32'b10);
    endtask

    task automatic pulse_op(input logic [2:0] o, input logic [15:0] bv);
        gin     = 1'b1;
        op      = o;
        buswire = bv;
        @(negedge clock);
        gin     = 1'b0;
    endtask

    initial begin
        logic [15:0] eg;
        logic [3:0]  ef;
        int          elat;
        int          lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  ro;

        vecs = '{
            '{16'h7FFF, OP_ADD,  16'h0001, 16'h8000, 4'b1001, 0},
            '{16'h1234, OP_SUB,  16'h1234, 16'h0000, 4'b0110, 0},
            '{16'h0102, OP_MUL,  16'h0304, 16'h0A08, 4'b0011, 16},
            '{16'h8001, OP_SHL,  16'h0003, 16'h0008, 4'b0000, 3},
            '{16'h8001, OP_SHL,  16'h0010, 16'h0000, 4'b0110, 16},
            '{16'h8001, OP_SHL,  16'h0000, 16'h8001, 4'b1000, 0},
            '{16'hF0F0, OP_AND,  16'h0FF0, 16'h00F0, 4'b0000, 0},
            '{16'hF000, OP_OR,   16'h000F, 16'hF00F, 4'b1000, 0},
            '{16'hAAAA, OP_XOR,  16'hAAAA, 16'h0000, 4'b0100, 0},
            '{16'h1234, OP_PASS, 16'h8000, 16'h8000, 4'b1000, 0},
            '{16'h0001, OP_SUB,  16'h0000, 16'hFFFF, 4'b1000, 0},
            '{16'hFFFF, OP_ADD,  16'h0001, 16'h0000, 4'b0110, 0},
            '{16'hFFFF, OP_SHL,  16'h001F, 16'h0000, 4'b0110, 16},
            '{16'h0001, OP_SUB,  16'h8000, 16'h7FFF, 4'b0011, 0},
            '{16'hFFFF, OP_MUL,  16'hFFFF, 16'h0001, 4'b0011, 16},
            '{16'h0001, OP_SHL,  16'h0023, 16'h0008, 4'b0000, 3}
        };

        repeat (2) @(negedge clock);
        chk("rst.g", 32'(aluout), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.f", 32'(flags), 32'h0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].o,
                     vecs[i].b, vecs[i].g, vecs[i].f, vecs[i].lat);
        end

        // Reset in the middle of a multiply.
        @(negedge clock);
        ain     = 1'b1;
        buswire = 16'h0003;
        @(negedge clock);
        ain = 1'b0;
        pulse_op(OP_MUL, 16'h0005);
        repeat (3) @(negedge clock);
        chk("midmul.busy", 32'(busy), 32'h1);
        resetn = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'h0);
        chk("midrst.done", 32'(done), 32'h0);
        chk("midrst.g", 32'(aluout), 32'h0);
        chk("midrst.f", 32'(flags), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        pulse_op(OP_ADD, 16'h0007);
        chk("midrst.a", 32'(aluout), 32'h0007);
        check_op("postrst.mul", 16'h0003, OP_MUL, 16'h0005,
                 16'h000F, 4'b0000, 16);

        // ain/gin while busy must be ignored.
        @(negedge clock);
        ain     = 1'b1;
        buswire = 16'h0102;
        @(negedge clock);
        ain = 1'b0;
        pulse_op(OP_MUL, 16'h0304);
        repeat (4) @(negedge clock);
        ain     = 1'b1;
        gin     = 1'b1;
        op      = OP_PASS;
        buswire = 16'hFFFF;
        @(negedge clock);
        ain = 1'b0;
        gin = 1'b0;
        lat = 0;
        while (busy && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        chk("busyign.lat", 32'(lat), 32'd11);
        chk("busyign.g", 32'(aluout), 32'h0A08);
        chk("busyign.f", 32'(flags), 32'(4'b0011 & FMASK));
        chk("busyign.done", 32'(done), 32'h1);
        pulse_op(OP_ADD, 16'h0000);
        chk("busyign.a", 32'(aluout), 32'h0102);

        // Same-edge ain+gin, then gin on the done cycle.
        @(negedge clock);
        ain     = 1'b1;
        buswire = 16'h0001;
        @(negedge clock);
        gin     = 1'b1;
        op      = OP_ADD;
        buswire = 16'h0010;
        @(negedge clock);
        ain = 1'b0;
        gin = 1'b0;
        chk("same.g", 32'(aluout), 32'h0011);
        chk("same.done", 32'(done), 32'h1);
        pulse_op(OP_ADD, 16'h0000);
        chk("same.a", 32'(aluout), 32'h0010);
        chk("same.done2", 32'(done), 32'h1);

        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = 3'($urandom_range(0, 7));
            model(ra, ro, rb, eg, ef, elat);
            check_op($sformatf("rnd%0d_op%0d", k, ro), ra, ro, rb,
                     eg, ef, elat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the single-cycle add/sub ALU datapath: operand register A, result register G, shared bus input.
- Adds logic ops, PASS, multi-cycle shift-add multiply and multi-cycle left shift.
- Start/busy/done handshake and registered status flags.
- Sits between the processor bus and the control FSM, which drives ain/gin and waits on done.

Parameters:
- WIDTH, 16, datapath width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width; holds WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- buswire  in  WIDTH  shared bus; operand B, or the A-load value.
- ain  in  1  load A from buswire.
- gin  in  1  start operation `op` with B = buswire.
- op  in  3  operation select, sampled with gin.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: G and flags updated.
- aluout  out  WIDTH  G register.
- flags  out  4  {N, Z, C, V}, registered with G.

Behaviour:
- Reset (async, resetn=0): A=0, G=0, flags=0, busy=0, done=0, FSM=IDLE. Applies mid-operation; the partial result is discarded.
- FSM states: IDLE, MUL, SHL.
- ain: when IDLE and ain=1, A<=buswire at the edge. Ignored while busy.
- gin: when IDLE and gin=1, op is sampled. Ignored while busy.
- ain and gin on the same edge: the op uses the old A; A loads the new value.
- Op codes:
  - 000 ADD: G = buswire + A.
  - 001 SUB: G = buswire − A, computed as buswire + ~A + 1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 PASS: G = buswire.
  - 110 MUL: G = low WIDTH bits of A×B, unsigned.
  - 111 SHL: G = A << B[CNT_W-1:0].
- Single-cycle ops (000–101): G and flags update at the gin edge. done=1 during the following cycle. busy stays 0.
- MUL:
  - gin edge loads multiplicand=A, multiplier=B, acc=0 (2·WIDTH bits), cnt=WIDTH; busy=1; FSM→MUL.
  - Each edge: if multiplier[0], acc += multiplicand << (WIDTH−cnt); multiplier >>= 1; cnt−−.
  - At the edge where cnt reaches 0: G=acc[WIDTH-1:0], FSM→IDLE, busy=0, done pulses next cycle.
  - Latency: WIDTH edges after gin.
- SHL:
  - n = B[CNT_W-1:0], saturated to WIDTH.
  - n=0: single-cycle, G=A.
  - Otherwise busy=1 and one bit shifts per edge; G updates after n edges; done as for MUL.
  - n≥WIDTH gives G=0.
- Flags:
  - N = G[WIDTH-1]; Z = (G==0).
  - ADD/SUB: C = carry-out (for SUB, C=1 means no borrow); V = signed overflow.
  - MUL: C = V = (acc[2W-1:W] ≠ 0).
  - SHL: C = last bit shifted out, V=0.
  - Logic/PASS: C = V = 0.
- Unchanged by ain: G and flags.
- done and gin on the same cycle while IDLE: the new op starts normally.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: flags register and logic are present as specified.
- Undefined: the flag logic is not built and flags is tied to 4'b0000; all other behaviour is identical.

Decomposition:
- Package alu_pkg: op encoding constants (OP_ADD…OP_SHL), state encoding (ST_IDLE, ST_MUL, ST_SHL), flag bit indices (FLG_N, FLG_Z, FLG_C, FLG_V).
- One sub-module, alu_addsub: parametrised WIDTH ripple adder/subtractor.
  - Inputs: in1, in2, sub. Outputs: s, cout, ovf.
  - Reused for ADD/SUB and for the MUL accumulate step.

Test Plan (WIDTH=16):
- Reset mid-MUL: A=0x0003, gin op=110 B=0x0005; drop resetn 4 cycles later → busy=0, done=0, aluout=0, A=0; after release, MUL again runs the full 16 cycles.
- ADD overflow: A=0x7FFF, gin op=000 B=0x0001 → next cycle aluout=0x8000, done=1 for one cycle, flags N=1 Z=0 C=0 V=1.
- SUB equal: A=0x1234, gin op=001 B=0x1234 → aluout=0x0000, Z=1, C=1, V=0.
- MUL: A=0x0102, gin op=110 B=0x0304 → busy high 16 cycles; then aluout=0x0A08, C=V=1, single done pulse. gin and ain asserted while busy → A and the result are unaffected.
- SHL: A=0x8001, gin op=111 B=0x0003 → busy 3 cycles; aluout=0x0008, C=0. Same with B=0x0010 → aluout=0x0000, Z=1. B=0 → single-cycle, aluout=0x8001.
- Same-edge ain+gin: A=0x0001; on one edge ain=1, gin=1, op=000, buswire=0x0010 → aluout=0x0011 and A=0x0010 afterwards. With ALU_FLAGS_EN undefined, flags stays 0 throughout.
